// File: rtl/hdmi_tx_gen.sv
// 640x480@60 HDMI timing generator that drains the ADV FIFO
// during the active region and aligns pixel data with DE.
module hdmi_tx_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   DATA_W   = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              rdempty_adv,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              rdreq_adv,
  output logic              HDMI_TX_DE,
  output logic              HDMI_TX_HS,
  output logic              HDMI_TX_VS,
  output logic [DATA_W-1:0] HDMI_TX_D,
  output logic [9:0]        h_cnt,
  output logic [9:0]        v_cnt,
  output logic [31:0]       frame_num,
  output logic [15:0]       underflow_cnt,
  output logic              underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   line_end, frame_end;
  logic   active, run_act;
  logic   hs_on, vs_on;
  logic   rd_q;

  assign line_end  = h_cnt == 10'(H_TOTAL - 1);
  assign frame_end = line_end &&
                     v_cnt == 10'(V_TOTAL - 1);
  assign active    = h_cnt < 10'(H_ACTIVE) &&
                     v_cnt < 10'(V_ACTIVE);
  assign run_act   = state == S_RUN && active;
  assign rdreq_adv = run_act && !rdempty_adv;

  assign hs_on = h_cnt >= 10'(HS_BEG) &&
                 h_cnt <  10'(HS_END);
  assign vs_on = v_cnt >= 10'(VS_BEG) &&
                 v_cnt <  10'(VS_END);

  // Data arrives one clock after the read, same cycle as DE.
  assign HDMI_TX_D = rd_q ? fifo_q : '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (en) state_nx = S_SYNC;
      S_SYNC:
        if (frame_end) begin
          if (!en)
            state_nx = S_IDLE;
          else if (!rdempty_adv)
            state_nx = S_RUN;
        end
      S_RUN:
        if (frame_end)
          state_nx = en ? S_RUN : S_SYNC;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (line_end) begin
        h_cnt <= '0;
        v_cnt <= frame_end ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HDMI_TX_DE <= 1'b0;
      HDMI_TX_HS <= ~SYNC_POL;
      HDMI_TX_VS <= ~SYNC_POL;
      rd_q       <= 1'b0;
    end else begin
      HDMI_TX_DE <= run_act;
      HDMI_TX_HS <= hs_on ? SYNC_POL : ~SYNC_POL;
      HDMI_TX_VS <= vs_on ? SYNC_POL : ~SYNC_POL;
      rd_q       <= rdreq_adv;
    end
  end

  // Starved pixels still consume their slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_num     <= '0;
      underflow_cnt <= '0;
      underflow     <= 1'b0;
    end else begin
      if (state == S_RUN && frame_end)
        frame_num <= frame_num + 32'd1;
      if (run_act && rdempty_adv) begin
        underflow <= 1'b1;
        if (underflow_cnt != 16'hFFFF)
          underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_tx_gen.sv
// Randomized bench for hdmi_tx_gen against a linear-position
// frame model, on a shrunken raster to keep runs short.
module tb_hdmi_tx_gen;

  localparam int HA  = 16;
  localparam int HFP = 4;
  localparam int HSY = 8;
  localparam int HBP = 4;
  localparam int VA  = 12;
  localparam int VFP = 2;
  localparam int VSY = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FT  = HT * VT;
  localparam int N   = 30000;
  localparam int RST_AT = 15123;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        rdempty_adv;
  logic [23:0] fifo_q;
  logic        rdreq_adv;
  logic        de, hs, vs;
  logic [23:0] d;
  logic [9:0]  h_cnt, v_cnt;
  logic [31:0] frame_num;
  logic [15:0] underflow_cnt;
  logic        underflow;

  hdmi_tx_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1'b0), .DATA_W(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .rdempty_adv(rdempty_adv),
    .fifo_q(fifo_q),
    .rdreq_adv(rdreq_adv),
    .HDMI_TX_DE(de),
    .HDMI_TX_HS(hs),
    .HDMI_TX_VS(vs),
    .HDMI_TX_D(d),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .frame_num(frame_num),
    .underflow_cnt(underflow_cnt),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int unsigned k);
    logic [31:0] x;
    x = k * 32'h9E3779B9 + 32'h1234567;
    return x[31:8];
  endfunction

  // FIFO: each read exposes the next sequence word a clock later.
  int unsigned rd_k;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q <= '0;
      rd_k   <= 0;
    end else if (rdreq_adv) begin
      fifo_q <= pix(rd_k);
      rd_k   <= rd_k + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s @%0t: got %0h want %0h",
                 tag, $time, got, exp);
    end
  endtask

  // Model: mode 0 idle, 1 sync-only, 2 streaming.
  int          m, p;
  int unsigned k;
  logic        e_de, e_hs, e_vs;
  logic [23:0] e_d;
  logic [31:0] e_fn;
  int          e_uc;
  logic        e_uf;

  function automatic logic in_act(input int pos);
    return (pos % HT) < HA && (pos / HT) < VA;
  endfunction

  task automatic model_reset();
    m = 0; p = 0; k = 0;
    e_de = 0; e_hs = 1; e_vs = 1; e_d = 0;
    e_fn = 0; e_uc = 0; e_uf = 0;
  endtask

  task automatic model_step();
    int  h, v;
    logic act, run, fend;
    h = p % HT;
    v = p / HT;
    act = in_act(p);
    run = m == 2;
    fend = p == FT - 1;
    e_de = run && act;
    e_hs = !(h >= HA + HFP && h < HA + HFP + HSY);
    e_vs = !(v >= VA + VFP && v < VA + VFP + VSY);
    if (run && act && !rdempty_adv) begin
      e_d = pix(k);
      k++;
    end else begin
      e_d = 0;
    end
    if (run && act && rdempty_adv) begin
      e_uf = 1;
      if (e_uc < 65535) e_uc++;
    end
    if (m == 0) begin
      if (en) m = 1;
    end else begin
      p = (p + 1) % FT;
      if (fend) begin
        if (m == 2) begin
          e_fn++;
          m = en ? 2 : 1;
        end else if (!en) begin
          m = 0;
        end else if (!rdempty_adv) begin
          m = 2;
        end
      end
    end
  endtask

  task automatic check_regs();
    check("h_cnt", 32'(h_cnt), 32'(p % HT));
    check("v_cnt", 32'(v_cnt), 32'(p / HT));
    check("de", 32'(de), 32'(e_de));
    check("hs", 32'(hs), 32'(e_hs));
    check("vs", 32'(vs), 32'(e_vs));
    check("data", 32'(d), 32'(e_d));
    check("frame_num", frame_num, e_fn);
    check("uf_cnt", 32'(underflow_cnt), 32'(e_uc));
    check("uf_flag", 32'(underflow), 32'(e_uf));
  endtask

  initial begin
    int burst;
    logic exp_rd;
    burst = 0;
    reset = 1'b0;
    en = 1'b0;
    rdempty_adv = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (i >= 5) reset = 1'b1;
      check_regs();
      if (i < 1000) begin
        en = 1'b0;
        rdempty_adv = 1'b0;
      end else begin
        if (i == 1000)
          en = 1'b1;
        else if ($urandom_range(0, 399) == 0)
          en = ~en;
        if (burst > 0) begin
          burst--;
          rdempty_adv = 1'b1;
        end else if ($urandom_range(0, 39) == 0) begin
          burst = $urandom_range(0, 30);
          rdempty_adv = 1'b1;
        end else begin
          rdempty_adv = 1'b0;
        end
      end
      #1;
      exp_rd = reset && m == 2 && in_act(p) &&
               !rdempty_adv;
      check("rdreq", 32'(rdreq_adv), 32'(exp_rd));
      if (i == RST_AT) begin
        #1 reset = 1'b0;
        #1 model_reset();
        check_regs();
        check("rdreq_rst", 32'(rdreq_adv), 32'd0);
      end else if (reset) begin
        model_step();
      end
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/hdmi_tx_gen.md
Name: hdmi_tx_gen

Overview:
Output-side video timing generator and ADV FIFO drain, driven by the 25.2 MHz pixel clock. It generates 640x480@60 HS/VS/DE and issues read requests to the ADV FIFO exactly during the active region. It presents aligned pixel data to the HDMI transmitter. It is the consumer of the ADV FIFO that the capture controller fills, and it is the source of HDMI_TX_DE consumed by that controller.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, HS pulse width (clocks)
H_BP, 48, horizontal back porch (clocks); H_TOTAL = sum = 800
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, VS pulse width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
SYNC_POL, 0, asserted level of HS and VS (0 = active-low)
DATA_W, 24, pixel width

Ports:
clk  in  1  pixel clock (25.2 MHz)
reset  in  1  asynchronous active-low reset
en  in  1  stream enable from the top-level control (high in stream state)
rdempty_adv  in  1  ADV FIFO empty
fifo_q  in  DATA_W  ADV FIFO read data (normal mode: valid 1 clk after rdreq)
rdreq_adv  out  1  ADV FIFO read request (combinational)
HDMI_TX_DE  out  1  data enable (registered)
HDMI_TX_HS  out  1  horizontal sync (registered)
HDMI_TX_VS  out  1  vertical sync (registered)
HDMI_TX_D  out  DATA_W  pixel data (registered/aligned with DE)
h_cnt  out  10  horizontal position, 0..H_TOTAL-1
v_cnt  out  10  vertical position, 0..V_TOTAL-1
frame_num  out  32  completed streamed frames
underflow_cnt  out  16  active pixels with FIFO empty, saturating
underflow  out  1  sticky underflow flag

Behaviour:
- Reset (async, reset=0): state=S_IDLE; h_cnt=v_cnt=0; HDMI_TX_DE=0; HS and VS = ~SYNC_POL; HDMI_TX_D=0; frame_num=0; underflow_cnt=0; underflow=0. rdreq_adv=0 while in reset and in S_IDLE.
- Counters: h_cnt increments every clk outside S_IDLE. When h_cnt=H_TOTAL-1, h_cnt goes to 0 and v_cnt increments. When v_cnt also = V_TOTAL-1, v_cnt goes to 0. "frame_end" = (h_cnt=H_TOTAL-1 & v_cnt=V_TOTAL-1).
- active = h_cnt<H_ACTIVE & v_cnt<V_ACTIVE.
- State machine:
  - S_IDLE: counters held at 0. Go to S_SYNC when en=1.
  - S_SYNC: timing runs, DE never asserted, no reads. At frame_end: go to S_RUN if en=1 & rdempty_adv=0; go to S_IDLE if en=0; otherwise stay.
  - S_RUN: streaming. At frame_end: frame_num += 1 (wraps at 2^32). Next state S_RUN if en=1, else S_SYNC. Deassertion of en mid-frame is ignored until frame_end; the frame always completes.
  - Illegal state encoding: go to S_IDLE.
- rdreq_adv = (state=S_RUN) & active & ~rdempty_adv. Combinational, same cycle as the counter position.
- Output pipeline (1 clk latency from counters):
  - HDMI_TX_DE <= (state=S_RUN) & active.
  - HS <= SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
  - VS <= SYNC_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else ~SYNC_POL. VS is evaluated per clock on v_cnt, so edges coincide with the h_cnt=0 transition.
  - HDMI_TX_D = fifo_q when the previous cycle issued rdreq_adv; 0 when DE=1 but no read was issued (underflow); 0 when DE=0.
- Underflow: (state=S_RUN) & active & rdempty_adv -> underflow_cnt += 1, saturating at 16'hFFFF, and underflow=1 (sticky until reset). The pixel slot is still consumed (black), so timing never stalls.
- HS/VS toggle in S_SYNC and S_RUN, so the sink locks before data is streamed.

Test Plan:
- Reset, en=0 for 1000 clk -> h_cnt=v_cnt=0, DE=0, HS=VS=1, rdreq_adv=0, HDMI_TX_D=0.
- en=1 with FIFO never empty -> first DE rising edge occurs exactly 420000 clk (one full frame) + 1 clk after S_SYNC entry. Per line: 640 DE clocks, HS low for 96 clk starting at h_cnt=656 (+1 pipeline). VS low on lines 490–491. 307200 rdreq per frame; frame_num=1 after the frame.
- Data alignment: FIFO returns incrementing values 0,1,2,... -> HDMI_TX_D equals 0 on the first DE cycle, 639 on the last of line 0, and 640 at the start of line 1.
- Force rdempty_adv=1 for 5 active clocks mid-line 100 -> rdreq_adv=0 on those clocks, HDMI_TX_D=0 on the 5 DE cycles, underflow_cnt=5, underflow=1, and HS/VS timing unchanged.
- Drop en at v_cnt=200 -> DE continues through line 479; at frame_end the block enters S_SYNC; frame_num increments once; no rdreq afterwards. The next frame_end with en=0 returns the block to S_IDLE with counters at 0.
- Assert reset mid-line at h_cnt=300 -> all outputs take their reset values immediately (asynchronously). After release with en=1, the block restarts in S_SYNC from h_cnt=0.
